// File: rtl/cdb_arbiter.sv
// ---------------------------------------------------------------------------
// cdb_arbiter
//
// Common-data-bus arbiter and broadcaster. Completed results from the ALU and
// the load/store buffer are each queued in their own FIFO. At most one result
// per cycle is put onto the registered CDB. Round-robin priority alternates
// between the two sources whenever both have something to send.
//
// Optional feature (macro CDB_BYPASS_EN):
//   When defined, a result that arrives at an empty queue and would win
//   arbitration in that same cycle goes straight into the CDB registers. It
//   is never written to the queue, so latency drops from 2 cycles to 1.
//   When undefined, every result passes through its FIFO.
//
// Parameters:
//   ROB_ADDR     RoB index width
//   QDEPTH       entries per source queue (power of two, >= 2)
//
// Ports:
//   clk_in       clock, rising edge
//   rst_n_in     asynchronous active-low reset
//   rdy_in       global enable; when low, all state holds
//   flush_in     mispredict clear (acts only when rdy_in is high)
//   alu_*        ALU result offer: valid/ready handshake with regid, value, robidx
//   lsb_*        LSB result offer: same layout as the ALU ports
//   cdb_*        registered broadcast: valid, regid, value, RoB index
// ---------------------------------------------------------------------------
module cdb_arbiter #(
  parameter int ROB_ADDR = 4,
  parameter int QDEPTH   = 4
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic                rdy_in,
  input  logic                flush_in,

  input  logic                alu_valid,
  output logic                alu_ready,
  input  logic [4:0]          alu_regid,
  input  logic [31:0]         alu_value,
  input  logic [ROB_ADDR-1:0] alu_robidx,

  input  logic                lsb_valid,
  output logic                lsb_ready,
  input  logic [4:0]          lsb_regid,
  input  logic [31:0]         lsb_value,
  input  logic [ROB_ADDR-1:0] lsb_robidx,

  output logic                cdb_valid,
  output logic [4:0]          cdb_regid,
  output logic [31:0]         cdb_value,
  output logic [ROB_ADDR-1:0] cdb_RoBindex
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  // Entry layout: {regid, value, robidx}
  localparam int EW = 5 + 32 + ROB_ADDR;

  // Index 0 is the ALU, index 1 is the LSB; this matches the prio encoding.
  logic [1:0]    src_valid;
  logic [EW-1:0] src_entry [2];
  logic [EW-1:0] head      [2];

  logic [1:0]    full;
  logic [1:0]    empty;
  logic [1:0]    ready;
  logic [1:0]    hs;
  logic [1:0]    push;
  logic [1:0]    pop;
  logic [1:0]    req;
  logic [1:0]    grant;
  logic [1:0]    bypass;

  logic          prio;
  logic [EW-1:0] win_entry;

  assign src_valid    = {lsb_valid, alu_valid};
  assign src_entry[0] = {alu_regid, alu_value, alu_robidx};
  assign src_entry[1] = {lsb_regid, lsb_value, lsb_robidx};

  assign alu_ready = ready[0];
  assign lsb_ready = ready[1];

  // -------------------------------------------------------------------------
  // Per-source FIFO
  // -------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
      logic [EW-1:0] mem [QDEPTH];
      logic [PW-1:0] rd_ptr;
      logic [PW-1:0] wr_ptr;
      logic [CW-1:0] count;

      assign full[gi]  = (count == CW'(QDEPTH));
      assign empty[gi] = (count == '0);

      // Ready looks only at the count at the start of the cycle, never at a
      // pop happening in the same cycle. Held low during reset.
      assign ready[gi] = rst_n_in && rdy_in && !flush_in && !full[gi];
      assign hs[gi]    = src_valid[gi] && ready[gi];
      assign push[gi]  = hs[gi] && !bypass[gi];
      assign pop[gi]   = grant[gi] && !empty[gi];
      assign head[gi]  = mem[rd_ptr];

      // Storage carries no reset; only the pointers define what is valid.
      always_ff @(posedge clk_in) begin
        if (push[gi]) begin
          mem[wr_ptr] <= src_entry[gi];
        end
      end

      always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
          rd_ptr <= '0;
          wr_ptr <= '0;
          count  <= '0;
        end else if (rdy_in) begin
          if (flush_in) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
          end else begin
            if (push[gi]) begin
              wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop[gi]) begin
              rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push[gi], pop[gi]})
              2'b10:   count <= count + CW'(1);
              2'b01:   count <= count - CW'(1);
              default: count <= count;
            endcase
          end
        end
      end
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Arbitration
  // -------------------------------------------------------------------------
  always_comb begin
    req = ~empty;
`ifdef CDB_BYPASS_EN
    // An incoming handshake competes as if its queue already held it.
    req = ~empty | hs;
`endif
    grant = 2'b00;
    if (rdy_in && !flush_in) begin
      if (req == 2'b11) begin
        grant = prio ? 2'b10 : 2'b01;
      end else begin
        grant = req;
      end
    end
  end

`ifdef CDB_BYPASS_EN
  // A grant to an empty queue can only come from its own handshake.
  assign bypass = grant & empty;
`else
  assign bypass = 2'b00;
`endif

  always_comb begin
    win_entry = head[0];
    if (grant[1]) begin
      win_entry = bypass[1] ? src_entry[1] : head[1];
    end else if (bypass[0]) begin
      win_entry = src_entry[0];
    end
  end

  // -------------------------------------------------------------------------
  // CDB output registers and round-robin pointer
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cdb_valid    <= 1'b0;
      cdb_regid    <= '0;
      cdb_value    <= '0;
      cdb_RoBindex <= '0;
      prio         <= 1'b0;
    end else if (rdy_in) begin
      if (flush_in) begin
        cdb_valid <= 1'b0;
        prio      <= 1'b0;
      end else if (grant != 2'b00) begin
        cdb_valid    <= 1'b1;
        cdb_regid    <= win_entry[EW-1 -: 5];
        cdb_value    <= win_entry[ROB_ADDR +: 32];
        cdb_RoBindex <= win_entry[ROB_ADDR-1:0];
        // Hand priority to the source that did not win.
        prio         <= grant[0];
      end else begin
        // Data registers keep their last broadcast; only valid drops.
        cdb_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;
  localparam int RA = 4;
  localparam int QD = 4;

  logic          clk = 1'b0;
  logic          rst_n, rdy, flush;
  logic          alu_valid, alu_ready, lsb_valid, lsb_ready;
  logic [4:0]    alu_regid, lsb_regid;
  logic [31:0]   alu_value, lsb_value;
  logic [RA-1:0] alu_robidx, lsb_robidx;
  logic          cdb_valid;
  logic [4:0]    cdb_regid;
  logic [31:0]   cdb_value;
  logic [RA-1:0] cdb_RoBindex;

  always #5 clk = ~clk;

  cdb_arbiter #(.ROB_ADDR(RA), .QDEPTH(QD)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy), .flush_in(flush),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_regid(alu_regid),
    .alu_value(alu_value), .alu_robidx(alu_robidx),
    .lsb_valid(lsb_valid), .lsb_ready(lsb_ready), .lsb_regid(lsb_regid),
    .lsb_value(lsb_value), .lsb_robidx(lsb_robidx),
    .cdb_valid(cdb_valid), .cdb_regid(cdb_regid), .cdb_value(cdb_value),
    .cdb_RoBindex(cdb_RoBindex)
  );

  typedef struct {
    logic [4:0]    regid;
    logic [31:0]   value;
    logic [RA-1:0] rob;
    int            cyc;
  } ent_t;

  // Reference model: two plain queues, a priority bit and the expected
  // broadcast stream (each entry tagged with the cycle it must appear in).
  ent_t qa[$], ql[$], expq[$];
  bit   prio_m;
  ent_t last_e;
  bit   last_v;
  int   cyc;
  int   errors;
  int   checks;
  int   saw_lsb_full;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Model update on every rising edge, from the inputs held stable across it.
  always @(posedge clk) begin : model
    ent_t e, ia, il;
    bit   ha, hl, aa, al;
    int   w;
    cyc++;
    if (rst_n && rdy) begin
      if (flush) begin
        qa.delete();
        ql.delete();
        prio_m = 1'b0;
        last_v = 1'b0;
      end else begin
        ha = alu_valid && (qa.size() < QD);
        hl = lsb_valid && (ql.size() < QD);
        ia = '{alu_regid, alu_value, alu_robidx, 0};
        il = '{lsb_regid, lsb_value, lsb_robidx, 0};
        aa = qa.size() > 0;
        al = ql.size() > 0;
`ifdef CDB_BYPASS_EN
        aa = aa || ha;
        al = al || hl;
`endif
        w = -1;
        if (aa && al) w = prio_m ? 1 : 0;
        else if (aa)  w = 0;
        else if (al)  w = 1;
        if (w == 0) begin
          if (qa.size() > 0) e = qa.pop_front();
          else begin e = ia; ha = 1'b0; end
          prio_m = 1'b1;
        end else if (w == 1) begin
          if (ql.size() > 0) e = ql.pop_front();
          else begin e = il; hl = 1'b0; end
          prio_m = 1'b0;
        end
        if (w >= 0) begin
          e.cyc = cyc;
          expq.push_back(e);
          last_e = e;
          last_v = 1'b1;
        end else begin
          last_v = 1'b0;
        end
        if (ha) qa.push_back(ia);
        if (hl) ql.push_back(il);
      end
    end else if (rst_n && !rdy && last_v) begin
      // Frozen: the previous broadcast is presented again this cycle.
      e = last_e;
      e.cyc = cyc;
      expq.push_back(e);
    end
  end

  always @(negedge rst_n) begin
    qa.delete();
    ql.delete();
    expq.delete();
    prio_m = 1'b0;
    last_v = 1'b0;
  end

  // Monitor: sampled on the falling edge.
  always @(negedge clk) begin : monitor
    ent_t e;
    bit   exp_ra, exp_rl;
    exp_ra = rst_n && rdy && !flush && (qa.size() < QD);
    exp_rl = rst_n && rdy && !flush && (ql.size() < QD);
    chk("alu_ready", 64'(alu_ready), 64'(exp_ra));
    chk("lsb_ready", 64'(lsb_ready), 64'(exp_rl));
    if (rst_n && rdy && !flush && !lsb_ready) saw_lsb_full++;
    if (cdb_valid) begin
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL cdb_spurious: got valid regid=%0d rob=%0d at cyc %0d expected no broadcast",
                 cdb_regid, cdb_RoBindex, cyc);
      end else begin
        e = expq.pop_front();
        if (cdb_regid !== e.regid || cdb_value !== e.value ||
            cdb_RoBindex !== e.rob || e.cyc != cyc) begin
          errors++;
          $display("FAIL cdb_entry: got regid=%0d value=%h rob=%0d cyc=%0d expected regid=%0d value=%h rob=%0d cyc=%0d",
                   cdb_regid, cdb_value, cdb_RoBindex, cyc, e.regid, e.value, e.rob, e.cyc);
        end
      end
    end else begin
      checks++;
      if (expq.size() > 0 && expq[0].cyc <= cyc) begin
        e = expq.pop_front();
        errors++;
        $display("FAIL cdb_missing: got valid=0 at cyc %0d expected regid=%0d rob=%0d",
                 cyc, e.regid, e.rob);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    alu_valid = 1'b0;
    lsb_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic set_alu(bit v, logic [4:0] r, logic [31:0] val, logic [RA-1:0] rob);
    alu_valid = v; alu_regid = r; alu_value = val; alu_robidx = rob;
  endtask

  task automatic set_lsb(bit v, logic [4:0] r, logic [31:0] val, logic [RA-1:0] rob);
    lsb_valid = v; lsb_regid = r; lsb_value = val; lsb_robidx = rob;
  endtask

  // Asynchronous reset applied between edges; release away from the rising edge.
  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_cdb_valid", 64'(cdb_valid), 64'd0);
    chk("rst_cdb_regid", 64'(cdb_regid), 64'd0);
    chk("rst_cdb_value", 64'(cdb_value), 64'd0);
    chk("rst_cdb_rob", 64'(cdb_RoBindex), 64'd0);
    chk("rst_alu_ready", 64'(alu_ready), 64'd0);
    alu_valid = 1'b0;
    lsb_valid = 1'b0;
    flush = 1'b0;
    rdy = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    chk("rel_alu_ready", 64'(alu_ready), 64'd1);
    chk("rel_lsb_ready", 64'(lsb_ready), 64'd1);
  endtask

  initial begin
    errors = 0; checks = 0; cyc = 0; saw_lsb_full = 0;
    rst_n = 1'b1; rdy = 1'b1; flush = 1'b0;
    set_alu(1'b0, 5'd0, 32'd0, '0);
    set_lsb(1'b0, 5'd0, 32'd0, '0);
    #3;
    do_reset();

    // Single ALU result.
    step();
    set_alu(1'b1, 5'd5, 32'hDEADBEEF, 4'd3);
    step();
    idle(5);

    // Contention after reset: both saturated, queues fill, ALU first.
    do_reset();
    step();
    for (int i = 0; i < 12; i++) begin
      set_alu(1'b1, 5'(i + 1), $urandom, RA'(2 * i));
      set_lsb(1'b1, 5'(i + 16), $urandom, RA'(2 * i + 1));
      step();
    end
    idle(12);
    checks++;
    if (saw_lsb_full == 0) begin
      errors++;
      $display("FAIL lsb_full_seen: got %0d full cycles expected at least 1", saw_lsb_full);
    end

    // LSB-only back-to-back offers with rdy toggling.
    for (int i = 0; i < QD + 1; i++) begin
      set_lsb(1'b1, 5'(i + 2), $urandom, RA'(i));
      rdy = 1'b0;
      step();
      rdy = 1'b1;
      step();
    end
    idle(6);

    // Flush with entries queued.
    for (int i = 0; i < 4; i++) begin
      set_alu(1'b1, 5'(i + 8), $urandom, RA'(i));
      set_lsb(1'b1, 5'(i + 20), $urandom, RA'(i + 8));
      step();
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    idle(3);
    set_alu(1'b1, 5'd9, 32'h1234_5678, 4'd6);
    step();
    idle(4);

    // Freeze while the CDB holds {regid 7, robidx 1}.
    set_alu(1'b1, 5'd7, 32'h0000_0707, 4'd1);
    step();
    set_alu(1'b1, 5'd8, 32'h0000_0808, 4'd2);
    step();
    set_alu(1'b1, 5'd10, 32'h0000_0A0A, 4'd4);
    rdy = 1'b0;
    repeat (3) step();
    rdy = 1'b1;
    step();
    idle(5);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      set_alu($urandom_range(0, 99) < 55, 5'($urandom), $urandom, RA'($urandom));
      set_lsb($urandom_range(0, 99) < 55, 5'($urandom), $urandom, RA'($urandom));
      rdy   = $urandom_range(0, 99) < 85;
      flush = $urandom_range(0, 99) < 3;
      step();
    end
    flush = 1'b0;
    rdy = 1'b1;

    // Reset in the middle of a broadcast stream.
    for (int i = 0; i < 3; i++) begin
      set_alu(1'b1, 5'(i + 1), $urandom, RA'(i));
      set_lsb(1'b1, 5'(i + 4), $urandom, RA'(i + 4));
      step();
    end
    do_reset();
    step();
    set_lsb(1'b1, 5'd0, 32'hCAFE_F00D, 4'd15);
    step();
    idle(10);

    chk("expq_drained", 64'(expq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
